// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared lane constants and tx state enum (used by tx and byte-align receiver)
package lane_pkg;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP01,
        ST_LP00,
        ST_HS_ZERO,
        ST_HS_SYNC,
        ST_HS_DATA,
        ST_HS_TRAIL,
        ST_HS_EXIT
    } tx_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lane_hs_tx_if.sv
// rtl/lane_hs_tx_if.sv - payload byte stream from packet builder into the HS lane transmitter
interface lane_hs_tx_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );

endinterface

// File: rtl/lane_byte_shifter.sv
// rtl/lane_byte_shifter.sv - 8-bit load/shift register emitting LSB pair first, plus 2-bit phase
module lane_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic [1:0] pair,
    output logic [1:0] phase
);

    logic [7:0] shreg_q, shreg_d;
    logic [1:0] phase_q, phase_d;

    // A load always starts a fresh byte at phase 0; otherwise the phase free-runs mod 4.
    always_comb begin
        shreg_d = {2'b00, shreg_q[7:2]};
        phase_d = phase_q + 2'd1;
        if (load) begin
            shreg_d = load_byte;
            phase_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= 8'h00;
            phase_q <= 2'd0;
        end else begin
            shreg_q <= shreg_d;
            phase_q <= phase_d;
        end
    end

    assign pair  = shreg_q[1:0];
    assign phase = phase_q;

endmodule

// File: rtl/lane_hs_tx.sv
// rtl/lane_hs_tx.sv - single-lane D-PHY style HS burst transmitter
// Optional statistics outputs burst_cnt/byte_cnt when LANE_TX_STATS_EN is defined.
module lane_hs_tx
    import lane_pkg::*;
#(
    parameter int T_LPX      = 4,
    parameter int T_HS_ZERO  = 2,
    parameter int T_HS_TRAIL = 2,
    parameter int T_HS_EXIT  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_req,
    lane_hs_tx_if.slave  byte_if,
    output logic         lp_p,
    output logic         lp_n,
    output logic         hs_oe,
    output logic [1:0]   ddr_data,
    output logic         busy,
    output logic         underrun
`ifdef LANE_TX_STATS_EN
    ,
    output logic [15:0]  burst_cnt,
    output logic [31:0]  byte_cnt
`endif
);

    localparam int CNT_MAX = max4(T_LPX, T_HS_ZERO, T_HS_TRAIL, T_HS_EXIT);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LPX_END   = CW'(T_LPX - 1);
    localparam logic [CW-1:0] ZERO_END  = CW'(T_HS_ZERO - 1);
    localparam logic [CW-1:0] TRAIL_END = CW'(T_HS_TRAIL - 1);
    localparam logic [CW-1:0] EXIT_END  = CW'(T_HS_EXIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          sh_load;
    logic [7:0]    sh_byte;
    logic [1:0]    pair, phase;
    logic [1:0]    lp_c;
    logic          oe_c, ready_c, underrun_c, to_trail;

    lane_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_byte (sh_byte),
        .pair      (pair),
        .phase     (phase)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        sh_load    = 1'b0;
        sh_byte    = 8'h00;
        lp_c       = LP11;
        oe_c       = 1'b0;
        ready_c    = 1'b0;
        underrun_c = 1'b0;
        to_trail   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    state_d = ST_LP01;
                    cnt_d   = '0;
                end
            end
            ST_LP01: begin
                lp_c = LP01;
                if (cnt_q == LPX_END) begin
                    state_d = ST_LP00;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LP00: begin
                lp_c = LP00;
                if (cnt_q == LPX_END) begin
                    state_d = ST_HS_ZERO;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HS_ZERO: begin
                lp_c = LP00;
                oe_c = 1'b1;
                if (phase == 2'd3) begin
                    sh_load = 1'b1;
                    if (cnt_q == ZERO_END) begin
                        sh_byte = HS_SYNC_BYTE;
                        state_d = ST_HS_SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HS_SYNC, ST_HS_DATA: begin
                lp_c = LP00;
                oe_c = 1'b1;
                // The next byte is requested on the final pair so it follows with no bubble.
                if (phase == 2'd3) begin
                    if (state_q == ST_HS_DATA && last_q) begin
                        to_trail = 1'b1;
                    end else begin
                        ready_c = 1'b1;
                        if (byte_if.byte_valid) begin
                            sh_load = 1'b1;
                            sh_byte = byte_if.byte_data;
                            last_d  = byte_if.byte_last;
                            state_d = ST_HS_DATA;
                        end else begin
                            underrun_c = 1'b1;
                            to_trail   = 1'b1;
                        end
                    end
                end
            end
            ST_HS_TRAIL: begin
                lp_c = LP00;
                oe_c = 1'b1;
                if (phase == 2'd3) begin
                    if (cnt_q == TRAIL_END) begin
                        state_d = ST_HS_EXIT;
                        cnt_d   = '0;
                    end else begin
                        // pair[1] already holds the trail level; keep repeating it.
                        sh_load = 1'b1;
                        sh_byte = {8{pair[1]}};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            ST_HS_EXIT: begin
                if (cnt_q == EXIT_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Trail bits invert the last HS bit sent, which is pair[1] at phase 3.
        if (to_trail) begin
            state_d = ST_HS_TRAIL;
            cnt_d   = '0;
            sh_load = 1'b1;
            sh_byte = {8{~pair[1]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign {lp_p, lp_n}       = lp_c;
    assign hs_oe              = oe_c;
    assign ddr_data           = oe_c ? pair : 2'b00;
    assign busy               = (state_q != ST_IDLE);
    assign underrun           = underrun_c;
    assign byte_if.byte_ready = ready_c;

`ifdef LANE_TX_STATS_EN
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        if (state_d == ST_HS_SYNC && state_q != ST_HS_SYNC) burst_cnt_d = burst_cnt_q + 16'd1;
        if (ready_c && byte_if.byte_valid) byte_cnt_d = byte_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= 16'd0;
            byte_cnt_q  <= 32'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_lane_hs_tx.sv
// tb/tb_lane_hs_tx.sv - scoreboard bench for lane_hs_tx (stats checks when LANE_TX_STATS_EN)
module tb_lane_hs_tx;
    import lane_pkg::*;

    localparam int T_LPX      = 4;
    localparam int T_HS_ZERO  = 2;
    localparam int T_HS_TRAIL = 2;
    localparam int T_HS_EXIT  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_req;
    logic       lp_p, lp_n, hs_oe, busy, underrun;
    logic [1:0] ddr_data;
`ifdef LANE_TX_STATS_EN
    logic [15:0] burst_cnt;
    logic [31:0] byte_cnt;
`endif

    lane_hs_tx_if bif ();

    lane_hs_tx #(
        .T_LPX      (T_LPX),
        .T_HS_ZERO  (T_HS_ZERO),
        .T_HS_TRAIL (T_HS_TRAIL),
        .T_HS_EXIT  (T_HS_EXIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_req   (tx_req),
        .byte_if  (bif),
        .lp_p     (lp_p),
        .lp_n     (lp_n),
        .hs_oe    (hs_oe),
        .ddr_data (ddr_data),
        .busy     (busy),
        .underrun (underrun)
`ifdef LANE_TX_STATS_EN
        ,
        .burst_cnt (burst_cnt),
        .byte_cnt  (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lp;
        logic       oe;
        logic [1:0] ddr;
        logic       rdy;
        logic       ur;
        logic       bsy;
    } rec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       gap;
    } item_t;

    rec_t  exp_q[$];
    item_t item_q[$];
    int    n_pass = 0;
    int    n_chk  = 0;
    bit    mon_en = 1'b0;
    int    exp_bursts = 0;
    int    exp_bytes  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic rec_t mk(input logic [1:0] lp, input logic oe, input logic [1:0] ddr,
                                input logic rdy, input logic ur, input logic bsy);
        rec_t r;
        r.lp = lp; r.oe = oe; r.ddr = ddr; r.rdy = rdy; r.ur = ur; r.bsy = bsy;
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic rdy, input logic ur);
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(2'b00, 1'b1, 2'((b >> (2 * k)) & 8'h03),
                               (k == 3) ? rdy : 1'b0, (k == 3) ? ur : 1'b0, 1'b1));
    endtask

    // Expected lane per clk for one burst: u = index of the byte that is not ready in time (u >= n: none).
    task automatic push_burst(input logic [7:0] b[$], input int u, output int len);
        int   n, sent;
        bit   und;
        logic lastbit;
        n    = b.size();
        und  = (u < n);
        sent = und ? u : n;
        exp_q.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < T_LPX; i++) exp_q.push_back(mk(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < T_LPX; i++) exp_q.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 4 * T_HS_ZERO; i++) exp_q.push_back(mk(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1));
        push_byte(8'hB8, 1'b1, und && sent == 0);
        for (int i = 0; i < sent; i++)
            push_byte(b[i], (i < sent - 1) || (und && i == sent - 1), und && i == sent - 1);
        lastbit = (sent > 0) ? b[sent - 1][7] : 1'b1;
        for (int i = 0; i < 4 * T_HS_TRAIL; i++)
            exp_q.push_back(mk(2'b00, 1'b1, {2{~lastbit}}, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < T_HS_EXIT; i++) exp_q.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < sent; i++) item_q.push_back('{data: b[i], last: (i == n - 1), gap: 1'b0});
        if (und) item_q.push_back('{data: b[u], last: (u == n - 1), gap: 1'b1});
        exp_bursts++;
        exp_bytes += sent;
        len = 2 * T_LPX + 4 * T_HS_ZERO + 4 + 4 * sent + 4 * T_HS_TRAIL + T_HS_EXIT;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_burst(input logic [7:0] b[$], input int u);
        int len;
        @(posedge clk); #1;
        push_burst(b, u, len);
        tx_req = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        drain();
    endtask

    // Payload producer: offers the planned item and retires it once a ready clk passes.
    initial begin
        bit hs;
        bif.byte_data  = 8'h00;
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
        forever begin
            if (item_q.size() > 0) begin
                bif.byte_data  = item_q[0].data;
                bif.byte_last  = item_q[0].last;
                bif.byte_valid = !item_q[0].gap;
            end else begin
                bif.byte_valid = 1'b0;
                bif.byte_last  = 1'b0;
            end
            @(negedge clk);
            hs = bif.byte_ready;
            @(posedge clk); #1;
            if (hs && item_q.size() > 0) void'(item_q.pop_front());
        end
    end

    initial begin
        rec_t act, e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act = mk({lp_p, lp_n}, hs_oe, ddr_data, bif.byte_ready, underrun, busy);
                e   = (exp_q.size() > 0) ? exp_q.pop_front() : mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
                check("lane", 32'(act), 32'(e));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int len1, len2, n, u;
        rst    = 1'b1;
        tx_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lp", {lp_p, lp_n}, 2'b11);
        check("reset_oe_busy_ur", {hs_oe, busy, underrun, bif.byte_ready, ddr_data}, 6'b0);
        rst = 1'b0;
        mon_en = 1'b1;

        q = {8'h12, 8'h34};
        run_burst(q, 99);
        q = {8'hA5, 8'h3C, 8'hF0};
        run_burst(q, 1);
        q = {8'h7E};
        run_burst(q, 0);
        q = {8'hFF};
        run_burst(q, 99);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            u = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : n;
            run_burst(q, u);
        end

        // tx_req held through two bursts: HS-time requests are ignored, LP-11 gap is T_HS_EXIT+1
        @(posedge clk); #1;
        q = {8'h01, 8'h80, 8'h55};
        push_burst(q, 99, len1);
        q = {8'hC3, 8'h99};
        push_burst(q, 1, len2);
        tx_req = 1'b1;
        repeat (len1 + 2) @(posedge clk);
        #1;
        tx_req = 1'b0;
        drain();

`ifdef LANE_TX_STATS_EN
        @(negedge clk);
        check("burst_cnt_pre", 32'(burst_cnt), 32'(exp_bursts));
        check("byte_cnt_pre", byte_cnt, 32'(exp_bytes));
`endif

        // reset in the middle of the first payload byte
        @(posedge clk); #1;
        q = {8'h5A, 8'h6B, 8'h7C};
        push_burst(q, 99, len1);
        tx_req = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("pre_rst_oe", hs_oe, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        item_q.delete();
        exp_bursts = 0;
        exp_bytes  = 0;
        check("rst_lp", {lp_p, lp_n}, 2'b11);
        check("rst_oe_rdy_busy", {hs_oe, bif.byte_ready, busy, underrun, ddr_data}, 6'b0);
`ifdef LANE_TX_STATS_EN
        check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        check("rst_byte_cnt", byte_cnt, 32'd0);
`endif
        @(negedge clk);
        mon_en = 1'b1;

        for (int r = 0; r < 3; r++) begin
            q = {};
            for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
            run_burst(q, 99);
        end
`ifdef LANE_TX_STATS_EN
        @(negedge clk);
        check("burst_cnt", 32'(burst_cnt), 32'(exp_bursts));
        check("byte_cnt", byte_cnt, 32'(exp_bytes));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
